if_stage_mo: RTL

IF_STAGE_MO -- requirements
Module: if_stage_mo

---
 rtl/if_stage_mo_pkg.sv | 17 +
 rtl/if_stage_mo_if.sv | 19 +
 rtl/if_stage_mo_fifo.sv | 70 +++++++
 rtl/if_stage_mo.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/if_stage_mo_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package if_stage_mo_pkg;

  localparam int          FS_TO_DS_BUS_WD  = 71;
  localparam logic [4:0]  EX_ADEL          = 5'h04;
  localparam logic [4:0]  EX_TLBL          = 5'h02;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  typedef logic [FS_TO_DS_BUS_WD-1:0] fs_bus_t;

  // Both fetch exceptions report the fetch pc as badvaddr, so the flag follows ex.
  function automatic fs_bus_t pack_fs_entry(input logic ex, input logic [4:0] exccode,
                                            input logic [31:0] inst, input logic [31:0] pc);
    return {ex, exccode, ex, inst, pc};
  endfunction

endpackage

// File: rtl/if_stage_mo_if.sv
// Instruction SRAM-like bus between the fetch stage (master) and memory (slave).
// An address phase completes on a cycle with req && addrok; req and addr stay stable until then,
// and each accepted address returns exactly one dataok/rdata later, strictly in request order.
interface if_stage_mo_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addrok;
  logic        dataok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addrok, dataok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addrok, dataok, rdata);
endinterface

// File: rtl/if_stage_mo_fifo.sv
// Small synchronous FIFO with a flush that empties it; used for in-flight tags and the result queue.
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = next_ptr(wptr_q);
      end
      if (do_pop) rptr_d = next_ptr(rptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/if_stage_mo.sv
// Instruction fetch stage with up to OUTSTANDING in-flight requests and an in-order result queue.
// Optional macro IF_TLB_EN adds mapped-address translation through the s0_* TLB search port.
module if_stage_mo
  import if_stage_mo_pkg::*;
#(
  parameter int          OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic                       redir_valid,
  input  logic [31:0]                redir_pc,
  input  logic                       ws_cancel,
  input  logic [31:0]                new_pc,
`ifdef IF_TLB_EN
  output logic [18:0]                s0_vpn2,
  output logic                       s0_odd_page,
  output logic [7:0]                 s0_asid,
  input  logic [7:0]                 entryhi_asid,
  input  logic                       s0_found,
  input  logic [19:0]                s0_pfn,
  input  logic                       s0_v,
`endif
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  if_stage_mo_if.master              inst_sram
);
  localparam int CW = $clog2(OUTSTANDING) + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          hold_q, hold_d;
  logic          stall_q, stall_d;

  logic          flush, q_pop, q_push, ex_push, can_issue, req, hs, dok, drop;
  logic [31:0]   flush_pc, fetch_addr;
  logic          fetch_ex;
  logic [4:0]    fetch_code;
  logic [CW:0]   occ;
  logic [CW-1:0] inflight_next;
  fs_bus_t       q_din, q_head;
  logic          q_empty, q_full;
  logic [CW-1:0] q_count;
  logic [31:0]   tag_pc;
  logic          tag_empty, tag_full;
  logic [CW-1:0] tag_count;
`ifdef IF_TLB_EN
  logic          mapped;
`endif

  if_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk(clk), .reset(reset), .flush(1'b0),
    .push(hs), .push_data(fpc_q), .pop(dok),
    .head(tag_pc), .empty(tag_empty), .full(tag_full), .count(tag_count)
  );

  if_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(OUTSTANDING)) u_result_q (
    .clk(clk), .reset(reset), .flush(flush),
    .push(q_push), .push_data(q_din), .pop(q_pop),
    .head(q_head), .empty(q_empty), .full(q_full), .count(q_count)
  );

  always_comb begin
    flush      = ws_cancel | redir_valid;
    flush_pc   = ws_cancel ? new_pc : redir_pc;
    q_pop      = ~q_empty & ds_allowin;
    fetch_ex   = 1'b0;
    fetch_code = '0;
    fetch_addr = fpc_q;
`ifdef IF_TLB_EN
    mapped = (fpc_q[31:30] != 2'b10);
    if (mapped) fetch_addr = {s0_pfn, fpc_q[11:0]};
    if (fpc_q[1:0] != 2'b00) begin
      fetch_ex   = 1'b1;
      fetch_code = EX_ADEL;
    end else if (mapped && (!s0_found || !s0_v)) begin
      fetch_ex   = 1'b1;
      fetch_code = EX_TLBL;
    end
`else
    if (fpc_q[1:0] != 2'b00) begin
      fetch_ex   = 1'b1;
      fetch_code = EX_ADEL;
    end
`endif
    // A queue entry leaving this cycle frees its slot immediately, giving one fetch per cycle.
    occ       = {1'b0, tag_count} + {1'b0, q_count} - (CW+1)'(q_pop);
    can_issue = ~stall_q & ~fetch_ex & ~tag_full & (occ < (CW+1)'(OUTSTANDING));
    req       = ~reset & (hold_q | can_issue);
    hs        = req & inst_sram.addrok;
    dok       = inst_sram.dataok & ~tag_empty;
    drop      = (discard_q != '0);
    ex_push   = fetch_ex & ~stall_q & ~hold_q & tag_empty & ~q_full;
    q_push    = ~flush & ((dok & ~drop) | ex_push);
    q_din     = dok ? pack_fs_entry(1'b0, 5'd0, inst_sram.rdata, tag_pc)
                    : pack_fs_entry(1'b1, fetch_code, 32'd0, fpc_q);
    inflight_next = tag_count + CW'(hs) - CW'(dok);

    fpc_d     = fpc_q;
    discard_d = discard_q;
    hold_d    = req & ~inst_sram.addrok;
    stall_d   = stall_q | ex_push;
    if (hs) fpc_d = fpc_q + 32'd4;
    if (dok && drop) discard_d = discard_q - CW'(1);
    // Everything still outstanding after this cycle, including a request accepted now, is stale.
    if (flush) begin
      fpc_d     = flush_pc;
      discard_d = inflight_next;
      hold_d    = 1'b0;
      stall_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q     <= RESET_PC;
      discard_q <= '0;
      hold_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
      hold_q    <= hold_d;
      stall_q   <= stall_d;
    end
  end

  assign inst_sram.req   = req;
  assign inst_sram.addr  = fetch_addr;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'd2;
  assign inst_sram.wstrb = 4'd0;
  assign inst_sram.wdata = 32'd0;

  assign fs_to_ds_valid = ~q_empty;
  assign fs_to_ds_bus   = q_empty ? '0 : q_head;

`ifdef IF_TLB_EN
  assign s0_vpn2     = fpc_q[31:13];
  assign s0_odd_page = fpc_q[12];
  assign s0_asid     = entryhi_asid;
`endif

  a_no_orphan_dataok: assert property (@(posedge clk) disable iff (reset)
    !(inst_sram.dataok && tag_empty));

endmodule
